rc5_key_schedule: RTL
=====================

Name: rc5_key_schedule

Overview:
- Parametrised RC5-w/r/b key-expansion engine.
- Accepts a secret key of `B` bytes and packs it into the `C`-word array `L`.
- Initialises the round-key table `S` from the magic constants Pw/Qw, then runs the 3·max(T,C) mixing pass, one iteration per clock.
- The finished `S` table is exposed on a read port for the RC5 encrypt/decrypt datapath; `valid` marks it usable.

Parameters:
- `W`, 32, word size in bits. Legal values: 16, 32, 64. Selects Pw/Qw:
  - W=16: B7E1 / 9E37
  - W=32: B7E15163 / 9E3779B9
  - W=64: B7E151628AED2A6B / 9E3779B97F4A7C15
- `R`, 12, number of rounds. T = 2R+2 table entries.
- `B`, 16, key length in bytes, 1..255. C = max(1, ceil(8B/W)).
- `AW`, 6, read-address width. Must satisfy 2^AW ≥ T.

Ports:
- `clk`    in   1      rising-edge clock
- `rst`    in   1      asynchronous, active-low reset
- `start`  in   1      begin key expansion; sampled only in IDLE
- `key`    in   8B     key bytes; K[0] = `key[7:0]`, K[i] = `key[8i+7:8i]`
- `busy`   out  1      high from the cycle after `start` is accepted until `done`
- `done`   out  1      one-cycle pulse when `S` is complete
- `valid`  out  1      `S` table holds a complete schedule
- `s_addr` in   AW     read address into `S`
- `s_data` out  W      `S[s_addr]`, combinational read; zero if `s_addr` ≥ T

Behaviour:
- Reset (`rst`=0, asynchronous): FSM→IDLE; `busy`=0, `done`=0, `valid`=0; `A`, `B`, `i`, `j` and all `L`/`S` entries cleared to 0. Reset mid-operation aborts immediately; no partial result is flagged valid.
- IDLE: if `start`=1 at a posedge:
  - latch `key`; set `A`=`B`=0, counter `k`=0; `valid`←0; go to LOAD.
  - `start` in any state other than IDLE is ignored (no restart, no queueing).
- LOAD (C cycles): cycle k writes L[k] = little-endian packing of bytes K[k·W/8 … k·W/8+W/8−1].
  - Bytes beyond B−1 are zero (partial last word zero-padded in its high bytes).
- INIT (T cycles): S[0]=Pw; S[n]=S[n−1]+Qw mod 2^W, one entry per cycle.
- MIX (N = 3·max(T,C) cycles): indices i (mod T) and j (mod C) start at 0. Each cycle:
  - A' = (S[i] + A + B) <<< 3
  - B' = (L[j] + A' + B) <<< ((A'+B) mod W)
  - S[i]←A', L[j]←B', A←A', B←B'
  - i←(i+1) mod T, j←(j+1) mod C
  - All sums are modulo 2^W. Rotate amount uses only the low log2(W) bits; amount 0 leaves the value unchanged.
  - When T=C, i and j wrap on the same cycle.
- DONE (1 cycle): `done`=1, `busy`=0, `valid`←1; next state IDLE.
- Latency: `start` sampled at edge e0 → `done` high in the cycle after edge e0+C+T+N.
  - Default parameters: C=4, T=26, N=78, so 108 clocks of `busy`.
- `valid` stays 1 until the next accepted `start` or reset.
- `s_data` reads `S` at all times. Contents are meaningful only while `valid`=1.
- `key` may change after `start` is accepted without effect.
- `start` held high continuously: a new expansion begins on the first IDLE cycle after DONE.

Test Plan:
- Default params, key=0, pulse `start` → `busy` for 108 cycles, single-cycle `done`, then `valid`=1. Read S[0..25] and encrypt pt 00000000_00000000 with a software RC5-32/12 → ct 21A5DBEE_154B8F6D.
- Default params, key=128'hFFFEEEE58684FFF05FFE493853000434 → S[0..25] match the C golden model word-for-word. `s_addr`=26..63 → `s_data`=0.
- W=32, B=10 (C=3): after LOAD, L[2] = 0x0000_hhhh (upper two bytes zero). Final S matches golden model; total busy = 3+26+78 = 107 cycles.
- W=16, R=12, B=8, and W=64, R=24, B=32 → S matches golden model. Confirms Pw/Qw selection and rotate masking (4 / 6 bits).
- Drive `rst` low at MIX cycle 40 → outputs zero immediately; `valid` stays 0. A fresh `start` after release completes normally with the correct S.
- `start` re-pulsed during MIX → ignored, `done` timing unchanged. `start` held high → back-to-back expansions, each 108 busy cycles separated by one DONE cycle plus one IDLE cycle.

Source files
------------

// File: rtl/rc5_key_schedule.sv
// RC5-w/r/b key expansion: packs the secret key into L, seeds S from Pw/Qw,
// then runs the 3*max(T,C) mixing pass one iteration per clock.
module rc5_key_schedule #(
    parameter int W  = 32,
    parameter int R  = 12,
    parameter int B  = 16,
    parameter int AW = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [8*B-1:0]   key,
    output logic             busy,
    output logic             done,
    output logic             valid,
    input  logic [AW-1:0]    s_addr,
    output logic [W-1:0]     s_data
);
    localparam int T     = 2 * R + 2;
    localparam int C_RAW = (8 * B + W - 1) / W;
    localparam int C     = (C_RAW < 1) ? 1 : C_RAW;
    localparam int N     = 3 * ((T > C) ? T : C);
    localparam int LW    = $clog2(W);
    localparam int IW    = $clog2(T);
    localparam int JW    = (C > 1) ? $clog2(C) : 1;
    localparam int NW    = $clog2(N);
    localparam int KPW   = C * W;

    localparam logic [63:0] PW64 = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                   (W == 32) ? 64'h0000_0000_B7E1_5163 :
                                               64'hB7E1_5162_8AED_2A6B;
    localparam logic [63:0] QW64 = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                   (W == 32) ? 64'h0000_0000_9E37_79B9 :
                                               64'h9E37_79B9_7F4A_7C15;
    localparam logic [W-1:0] PW    = PW64[W-1:0];
    localparam logic [W-1:0] QW    = QW64[W-1:0];
    localparam logic [AW:0]  T_LIM = (AW + 1)'(T);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_INIT = 3'd2,
        ST_MIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] amt);
        logic [2*W-1:0] d;
        d = {x, x} << amt;
        return d[2*W-1:W];
    endfunction

    state_t           state_r, state_s;
    logic [8*B-1:0]   key_r;
    logic [KPW-1:0]   key_pad_s;
    logic [W-1:0]     key_word_s [C];
    logic [W-1:0]     s_tbl_r [T];
    logic [W-1:0]     l_tbl_r [C];
    logic [W-1:0]     a_r, b_r;
    logic [IW-1:0]    i_r;
    logic [JW-1:0]    j_r;
    logic [NW-1:0]    cnt_r;
    logic             busy_r, done_r, valid_r;
    logic             i_last_s, j_last_s, cnt_last_s;
    logic [W-1:0]     a_new_s, ab_sum_s, b_new_s, init_val_s;

    assign key_pad_s = KPW'(key_r);
    for (genvar g = 0; g < C; g++) begin : g_key_word
        assign key_word_s[g] = key_pad_s[g*W +: W];
    end

    assign i_last_s   = (i_r == IW'(T - 1));
    assign j_last_s   = (j_r == JW'(C - 1));
    assign cnt_last_s = (cnt_r == NW'(N - 1));

    // One mixing step and the next INIT entry, evaluated from current state
    always_comb begin
        a_new_s    = rotl(s_tbl_r[i_r] + a_r + b_r, LW'(3));
        ab_sum_s   = a_new_s + b_r;
        b_new_s    = rotl(l_tbl_r[j_r] + ab_sum_s, ab_sum_s[LW-1:0]);
        init_val_s = PW;
        if (i_r != '0) begin
            init_val_s = s_tbl_r[i_r - IW'(1)] + QW;
        end else begin
            init_val_s = PW;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (start)      state_s = ST_LOAD; else state_s = ST_IDLE;
            ST_LOAD: if (j_last_s)   state_s = ST_INIT; else state_s = ST_LOAD;
            ST_INIT: if (i_last_s)   state_s = ST_MIX;  else state_s = ST_INIT;
            ST_MIX:  if (cnt_last_s) state_s = ST_DONE; else state_s = ST_MIX;
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Status flags registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_LOAD) || (state_s == ST_INIT) || (state_s == ST_MIX);
            done_r <= (state_s == ST_DONE);
        end
    end

    // Key latch, L/S tables, mixing registers and indices
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            i_r     <= '0;
            j_r     <= '0;
            cnt_r   <= '0;
            valid_r <= 1'b0;
            for (int n = 0; n < T; n++) s_tbl_r[n] <= '0;
            for (int n = 0; n < C; n++) l_tbl_r[n] <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        key_r   <= key;
                        a_r     <= '0;
                        b_r     <= '0;
                        i_r     <= '0;
                        j_r     <= '0;
                        cnt_r   <= '0;
                        valid_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    l_tbl_r[j_r] <= key_word_s[j_r];
                    j_r          <= j_last_s ? '0 : j_r + JW'(1);
                end
                ST_INIT: begin
                    s_tbl_r[i_r] <= init_val_s;
                    i_r          <= i_last_s ? '0 : i_r + IW'(1);
                end
                ST_MIX: begin
                    s_tbl_r[i_r] <= a_new_s;
                    l_tbl_r[j_r] <= b_new_s;
                    a_r          <= a_new_s;
                    b_r          <= b_new_s;
                    i_r          <= i_last_s ? '0 : i_r + IW'(1);
                    j_r          <= j_last_s ? '0 : j_r + JW'(1);
                    cnt_r        <= cnt_r + NW'(1);
                end
                ST_DONE: begin
                    valid_r <= 1'b1;
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Combinational read port; addresses past the table read as zero
    always_comb begin
        s_data = '0;
        if ({1'b0, s_addr} < T_LIM) begin
            s_data = s_tbl_r[s_addr[IW-1:0]];
        end else begin
            s_data = '0;
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign valid = valid_r;

endmodule
